// File: rtl/fetch_stage.sv
// fetch_stage: rv32i instruction-fetch stage.
// Owns the PC, issues one word read at a time to the icache, buffers returned
// words in a QDEPTH-entry queue and presents {pc, instr} to decode.
// Optional build macro: FETCH_STALL_CNT_EN adds the stall_cycles counter port.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic        icache_resp,
  input  logic [31:0] icache_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QD_C = CW'(QDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic          r_read;
  logic [31:0]   r_addr;
  fq_entry_t     r_q [QDEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_occ;

  logic [31:0]   w_redir_pc;
  logic          w_enq;
  logic          w_deq;
  logic          w_unused_pc_lsb;

  // Low two bits of the redirect target are meaningless for word fetch
  assign w_redir_pc      = {redirect_pc[31:2], 2'b00};
  assign w_unused_pc_lsb = ^redirect_pc[1:0];

  // Only a live (non-draining) response is kept; a redirect in the same cycle kills it
  assign w_enq = (r_state == S_REQ) && icache_resp && !redirect;
  // Redirect wins over a dequeue in the same cycle
  assign w_deq = (r_occ != '0) && id_ready && !redirect;

  // Fetch FSM: one outstanding request, never aborted once issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_read     <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
          end else if (r_occ < QD_C) begin
            // Nothing outstanding in IDLE, so occ alone guarantees a free slot
            r_state <= S_REQ;
            r_read  <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            if (icache_resp) begin
              r_state <= S_IDLE;
              r_read  <= 1'b0;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (icache_resp) begin
            r_state    <= S_IDLE;
            r_read     <= 1'b0;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        S_DRAIN: begin
          if (redirect) r_fetch_pc <= w_redir_pc;
          if (icache_resp) begin
            r_state <= S_IDLE;
            r_read  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  // Fetch queue: circular buffer, flushed by redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= '0;
    end else if (redirect) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_occ <= '0;
    end else begin
      if (w_enq) begin
        r_q[r_wr] <= '{pc: r_fetch_pc, instr: icache_rdata};
        r_wr      <= r_wr + 1'b1;
      end
      if (w_deq) r_rd <= r_rd + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign icache_read    = r_read;
  assign icache_address = r_addr;
  assign if_valid       = (r_occ != '0);
  assign if_pc          = r_q[r_rd].pc;
  assign if_instr       = r_q[r_rd].instr;

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] r_stall;

  // Saturating count of cycles where decode was ready but had nothing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                        r_stall <= '0;
    else if (!if_valid && id_ready && (r_stall != '1))   r_stall <= r_stall + 32'd1;
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage with a transaction-level
// model (expected fetch PC, expected decode queue) and an icache responder.
module tb_fetch_stage;
  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0060;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        icache_read;
  logic [31:0] icache_address;
  logic        icache_resp;
  logic [31:0] icache_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  fetch_stage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk(clk), .reset_n(reset_n),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
`ifdef FETCH_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] next_pc, req_addr, m_stall;
  bit          req_live, prev_read, prev_resp, expect_rise;
  int          cnt, lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_reset(input int cyc);
    return (cyc < 3) || (cyc >= 300 && cyc < 302) || (cyc >= 2500 && cyc < 2503);
  endfunction

  initial begin
    reset_n = 1'b1; icache_resp = 1'b0; icache_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    next_pc = RPC; req_addr = RPC; m_stall = '0;
    req_live = 0; prev_read = 0; prev_resp = 0; expect_rise = 0;
    cnt = 0; lat = 2;
    #1 reset_n = 1'b0;
    for (int cyc = 0; cyc < 2600; cyc++) begin
      @(negedge clk);
      // ---- observe outputs of the cycle just begun ----
      if (!reset_n) begin
        chk("rst_read", {31'b0, icache_read}, 32'd0);
        chk("rst_addr", icache_address, RPC);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_instr", if_instr, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall", stall_cycles, 32'd0);
`endif
      end else begin
        if (expect_rise) chk("issue", {31'b0, icache_read}, 32'd1);
        if (prev_resp)   chk("read_drop", {31'b0, icache_read}, 32'd0);
        if (icache_read && !prev_read) begin
          chk("req_addr", icache_address, next_pc);
          req_addr = next_pc;
          req_live = 1;
        end else if (icache_read) begin
          chk("addr_hold", icache_address, req_addr);
        end
        chk("if_valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
          chk("if_pc", if_pc, mq[0].pc);
          chk("if_instr", if_instr, mq[0].instr);
        end
        if (mq.size() == QD) chk("full_noreq", {31'b0, icache_read}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("stall", stall_cycles, m_stall);
`endif
      end
      prev_read = icache_read;

      // ---- drive inputs for this cycle and advance the model ----
      if (in_reset(cyc)) begin
        reset_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; icache_resp = 1'b0;
        mq.delete(); next_pc = RPC; req_live = 0; prev_read = 0; prev_resp = 0;
        expect_rise = 0; cnt = 0; m_stall = '0;
      end else begin
        int occ_now;
        occ_now = mq.size();
        reset_n = 1'b1;
        if (cyc < 150) begin
          id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
        end else if (cyc < 300) begin
          id_ready = ((cyc / 10) % 2) == 1; redirect = 1'b0;
        end else begin
          id_ready = ($urandom_range(0, 3) != 0) && ((cyc % 64) >= 10);
          redirect = ($urandom_range(0, 15) == 0);
          case ($urandom_range(0, 4))
            0:       redirect_pc = 32'h0000_0200;
            1:       redirect_pc = 32'h0000_0103;
            2:       redirect_pc = 32'hFFFF_FFF8;
            3:       redirect_pc = 32'hFFFF_FFFD;
            default: redirect_pc = $urandom & 32'h0000_FFFF;
          endcase
        end
        icache_resp = 1'b0;
        if (icache_read) begin
          cnt++;
          if (cnt >= lat) begin
            icache_resp  = 1'b1;
            icache_rdata = $urandom;
            cnt = 0;
            lat = (cyc < 150) ? 2 : $urandom_range(1, 4);
          end
        end
        // An idle fetcher with room and no redirect must request next cycle
        expect_rise = !icache_read && (occ_now < QD) && !redirect;
        if (!(occ_now != 0) == 1'b1 && id_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (redirect) begin
          mq.delete();
          next_pc  = redirect_pc & 32'hFFFF_FFFC;
          req_live = 0;
        end else begin
          if ((occ_now != 0) && id_ready) void'(mq.pop_front());
          if (icache_resp && req_live) begin
            mq.push_back('{pc: req_addr, instr: icache_rdata});
            next_pc  = req_addr + 32'd4;
            req_live = 0;
          end
        end
        prev_resp = icache_resp;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
